// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - multicycle fetch/decode/exec/mem/wb stage controller
//
// Purpose:
//   Steps one instruction at a time through FETCH -> DECODE -> EXEC -> MEM -> WB.
//   Each stage receives a one-cycle *_en pulse on its first cycle. The controller
//   then waits for that stage's *_done pulse. MEM and WB are skipped according to
//   the opcode. A per-stage watchdog traps to ERROR if a stage never answers.
//
// Optional feature macro: SEQ_PERF_EN
//   When defined, stall_cycles counts the MEM cycles spent waiting for mem_done.
//   When undefined, stall_cycles is tied to zero.
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   start, stop               level requests: leave IDLE / return to IDLE at retire
//   opcode[5:0]               exec command; sampled when EXEC or MEM exits
//   {fetch,decode,exec,mem,wb}_done  stage completion pulses
//   {fetch,decode,exec,mem,wb}_en    stage start pulses (registered)
//   state[2:0]                IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 ERROR=7
//   busy, error               busy = active stage; error is sticky until rst
//   icount[ICNT_W-1:0]        retired instruction count (wraps)
//   stall_cycles[31:0]        MEM wait-cycle counter (SEQ_PERF_EN only)

module stage_sequencer #(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int ICNT_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [5:0]        opcode,
    input  logic              fetch_done,
    input  logic              decode_done,
    input  logic              exec_done,
    input  logic              mem_done,
    input  logic              wb_done,
    output logic              fetch_en,
    output logic              decode_en,
    output logic              exec_en,
    output logic              mem_en,
    output logic              wb_en,
    output logic [2:0]        state,
    output logic              busy,
    output logic              error,
    output logic [ICNT_W-1:0] icount,
    output logic [31:0]       stall_cycles
);

    localparam int              WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERROR  = 3'd7
    } state_t;

    state_t            state_q, state_d, target;
    logic [4:0]        en_q, en_d;      // {wb, mem, exec, decode, fetch}
    logic              busy_q, busy_d;
    logic              error_q, error_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [ICNT_W-1:0] icount_q, icount_d;

    logic need_mem, need_wb, done_ok, waiting, advance, retire;

    assign need_mem = (opcode[5:4] == 2'b10) | (opcode == 6'b110001) | (opcode == 6'b111001);
    assign need_wb  = !((opcode[5:3] == 3'b101) | (opcode == 6'b000010) |
                        (opcode == 6'b000100)   | (opcode == 6'b000101) |
                        (opcode == 6'b110010));

    assign waiting = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC) ||
                     (state_q == S_MEM)   || (state_q == S_WB);

    // Only the active stage's done counts, and never on its own enable cycle:
    // a stage cannot legally finish in the same cycle it was started.
    always_comb begin
        done_ok = 1'b0;
        case (state_q)
            S_FETCH:  done_ok = fetch_done  & ~en_q[0];
            S_DECODE: done_ok = decode_done & ~en_q[1];
            S_EXEC:   done_ok = exec_done   & ~en_q[2];
            S_MEM:    done_ok = mem_done    & ~en_q[3];
            S_WB:     done_ok = wb_done     & ~en_q[4];
            default:  done_ok = 1'b0;
        endcase
    end

    always_comb begin
        target  = state_q;
        advance = 1'b0;
        retire  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    advance = 1'b1;
                    target  = S_FETCH;
                end
            end
            S_FETCH: begin
                if (done_ok) begin
                    advance = 1'b1;
                    target  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (done_ok) begin
                    advance = 1'b1;
                    target  = S_EXEC;
                end
            end
            S_EXEC: begin
                if (done_ok) begin
                    advance = 1'b1;
                    if (need_mem)     target = S_MEM;
                    else if (need_wb) target = S_WB;
                    else              retire = 1'b1;
                end
            end
            S_MEM: begin
                if (done_ok) begin
                    advance = 1'b1;
                    if (need_wb) target = S_WB;
                    else         retire = 1'b1;
                end
            end
            S_WB: begin
                if (done_ok) begin
                    advance = 1'b1;
                    retire  = 1'b1;
                end
            end
            default: ;
        endcase

        // Retire goes straight back to FETCH; start is only looked at in IDLE.
        if (retire) target = stop ? S_IDLE : S_FETCH;

        icount_d = retire ? icount_q + 1'b1 : icount_q;

        state_d = state_q;
        wd_d    = wd_q;
        en_d    = 5'b00000;
        if (advance) begin
            state_d = target;
            wd_d    = '0;
            case (target)
                S_FETCH:  en_d = 5'b00001;
                S_DECODE: en_d = 5'b00010;
                S_EXEC:   en_d = 5'b00100;
                S_MEM:    en_d = 5'b01000;
                S_WB:     en_d = 5'b10000;
                default:  en_d = 5'b00000;
            endcase
        end else if (waiting && (wd_q == WD_LIMIT)) begin
            // A done arriving on this same cycle took the advance branch above.
            state_d = S_ERROR;
            wd_d    = '0;
        end else if (waiting) begin
            wd_d = wd_q + 1'b1;
        end

        busy_d  = (state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_EXEC) ||
                  (state_d == S_MEM)   || (state_d == S_WB);
        error_d = (state_d == S_ERROR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            en_q     <= 5'b00000;
            busy_q   <= 1'b0;
            error_q  <= 1'b0;
            wd_q     <= '0;
            icount_q <= '0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
            error_q  <= error_d;
            wd_q     <= wd_d;
            icount_q <= icount_d;
        end
    end

`ifdef SEQ_PERF_EN
    logic [31:0] stall_q;

    // Counts MEM cycles after mem_en in which mem_done is still low; saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 32'd0;
        end else if ((state_q == S_MEM) && !en_q[3] && !mem_done && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'd0;
`endif

    assign fetch_en  = en_q[0];
    assign decode_en = en_q[1];
    assign exec_en   = en_q[2];
    assign mem_en    = en_q[3];
    assign wb_en     = en_q[4];
    assign state     = state_q;
    assign busy      = busy_q;
    assign error     = error_q;
    assign icount    = icount_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - randomized self-checking bench for stage_sequencer

module tb_stage_sequencer;

    localparam int TMO = 8;
    localparam int ICW = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           stop = 1'b0;
    logic [5:0]     opcode = 6'd0;
    logic           fetch_done = 1'b0, decode_done = 1'b0, exec_done = 1'b0;
    logic           mem_done = 1'b0, wb_done = 1'b0;
    logic           fetch_en, decode_en, exec_en, mem_en, wb_en;
    logic [2:0]     state;
    logic           busy, error;
    logic [ICW-1:0] icount;
    logic [31:0]    stall_cycles;

    int             n_cmp = 0;
    int             n_bad = 0;
    logic [ICW-1:0] icount_exp = '0;
    logic [31:0]    stall_exp = 32'd0;

    stage_sequencer #(.TIMEOUT_CYCLES(TMO), .ICNT_W(ICW)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .opcode(opcode),
        .fetch_done(fetch_done), .decode_done(decode_done), .exec_done(exec_done),
        .mem_done(mem_done), .wb_done(wb_done),
        .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en),
        .mem_en(mem_en), .wb_en(wb_en),
        .state(state), .busy(busy), .error(error), .icount(icount),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    wire [4:0] en_vec = {wb_en, mem_en, exec_en, decode_en, fetch_en};

    // Opcode classes from the instruction-set rules (ranges rather than bit fields).
    function automatic bit model_mem(input logic [5:0] op);
        int v;
        v = int'(op);
        return (v >= 32 && v <= 47) || v == 49 || v == 57;
    endfunction

    function automatic bit model_wb(input logic [5:0] op);
        int v;
        v = int'(op);
        return !((v >= 40 && v <= 47) || v == 2 || v == 4 || v == 5 || v == 50);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_dones(input logic [4:0] v);
        {wb_done, mem_done, exec_done, decode_done, fetch_done} = v;
    endtask

    task automatic start_instr;
        n_cmp++;
        if (state !== 3'd0) begin
            n_bad++;
            $display("FAIL idle_before_start: state=%0d want 0", state);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Plays the stage units for one instruction, starting on its FETCH entry cycle.
    task automatic drive_instr(input logic [5:0] op, input bit stop_v, input int fixed_dly, input bit noise);
        int         stg[$];
        int         dly;
        int         s;
        logic [4:0] dn;
        logic [4:0] en_exp;
        stg = {1, 2, 3};
        if (model_mem(op)) stg.push_back(4);
        if (model_wb(op))  stg.push_back(5);
        foreach (stg[i]) begin
            s   = stg[i];
            dly = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, TMO - 1));
            for (int k = 0; k <= dly; k++) begin
                en_exp = (k == 0) ? (5'b00001 << (s - 1)) : 5'b00000;
                n_cmp++;
                if (state !== 3'(s)) begin
                    n_bad++;
                    $display("FAIL stage_state: op=%b k=%0d state=%0d want %0d", op, k, state, s);
                end
                n_cmp++;
                if (en_vec !== en_exp) begin
                    n_bad++;
                    $display("FAIL stage_en: op=%b stage=%0d k=%0d en=%b want %b", op, s, k, en_vec, en_exp);
                end
                n_cmp++;
                if (busy !== 1'b1 || error !== 1'b0) begin
                    n_bad++;
                    $display("FAIL stage_busy: busy=%b error=%b want 1 0", busy, error);
                end
                dn = noise ? 5'($urandom) : 5'b00000;
                if (k == dly)    dn[s - 1] = 1'b1;
                else if (k > 0)  dn[s - 1] = 1'b0;
                set_dones(dn);
                opcode = (s == 1) ? 6'($urandom) : op;
                stop   = (k == dly && i == stg.size() - 1) ? stop_v : 1'($urandom);
                start  = 1'($urandom);
                if (s == 4 && k > 0 && k < dly) stall_exp++;
                tick();
            end
        end
        set_dones(5'b00000);
        start = 1'b0;
        stop  = 1'b0;
        icount_exp++;
        n_cmp++;
        if (icount !== icount_exp) begin
            n_bad++;
            $display("FAIL icount: got %0d want %0d", icount, icount_exp);
        end
        n_cmp++;
`ifdef SEQ_PERF_EN
        if (stall_cycles !== stall_exp) begin
`else
        if (stall_cycles !== 32'd0) begin
`endif
            n_bad++;
            $display("FAIL stall_cycles: got %0d model %0d", stall_cycles, stall_exp);
        end
        if (stop_v) begin
            n_cmp++;
            if (state !== 3'd0 || en_vec !== 5'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL stop_to_idle: state=%0d en=%b busy=%b want 0 0 0", state, en_vec, busy);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_cmp++;
        if (state !== 3'd0 || en_vec !== 5'b0 || busy !== 1'b0 || error !== 1'b0 ||
            icount !== '0 || stall_cycles !== 32'd0) begin
            n_bad++;
            $display("FAIL %s: state=%0d en=%b busy=%b err=%b icnt=%0d stall=%0d want all 0",
                     tag, state, en_vec, busy, error, icount, stall_cycles);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        icount_exp = '0;
        stall_exp  = 32'd0;
    endtask

    task automatic test_reset;
        do_reset();
        check_reset_values("reset_values");
        tick();
        check_reset_values("idle_without_start");
    endtask

    task automatic test_basic;
        start_instr();
        drive_instr(6'b000000, 1'b1, 1, 1'b0);
        start_instr();
        drive_instr(6'b100011, 1'b1, TMO - 1, 1'b0);   // every done on the watchdog limit
    endtask

    task automatic test_load_stall;
        start_instr();
        drive_instr(6'b100011, 1'b1, 5, 1'b0);
    endtask

    task automatic test_store_branch;
        start_instr();
        drive_instr(6'b101011, 1'b0, 1, 1'b0);
        drive_instr(6'b000100, 1'b1, 2, 1'b0);
    endtask

    task automatic test_ignored_dones;
        start_instr();
        for (int n = 0; n < 4; n++) drive_instr(6'($urandom), n == 3, 0, 1'b1);
    endtask

    task automatic test_back_to_back;
        logic [5:0] op;
        bit         idle;
        idle = 1'b1;
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 9))
                0: op = 6'b000000;
                1: op = 6'b100011;
                2: op = 6'b101011;
                3: op = 6'b000100;
                4: op = 6'b110001;
                5: op = 6'b111001;
                6: op = 6'b110010;
                7: op = 6'b000101;
                default: op = 6'($urandom);
            endcase
            if (idle) start_instr();
            idle = ($urandom_range(0, 3) == 0) || (n == 23);
            drive_instr(op, idle, 0, 1'b1);
        end
    endtask

    task automatic test_reset_mid;
        start_instr();
        opcode = 6'b100011;
        for (int s = 1; s <= 3; s++) begin
            tick();
            set_dones(5'b00001 << (s - 1));
            tick();
            set_dones(5'b00000);
        end
        n_cmp++;
        if (state !== 3'd4 || mem_en !== 1'b1) begin
            n_bad++;
            $display("FAIL reach_mem: state=%0d mem_en=%b want 4 1", state, mem_en);
        end
        rst = 1'b1;
        #1;
        check_reset_values("async_reset_in_mem");
        tick();
        rst = 1'b0;
        icount_exp = '0;
        stall_exp  = 32'd0;
        check_reset_values("after_async_reset");
    endtask

    task automatic test_wrap;
        start_instr();
        for (int n = 0; n < 17; n++) drive_instr(6'b000000, n == 16, 1, 1'b0);
        n_cmp++;
        if (icount !== 4'd1) begin
            n_bad++;
            $display("FAIL icount_wrap: got %0d want 1", icount);
        end
    endtask

    task automatic test_timeout;
        do_reset();
        start_instr();
        opcode = 6'b000000;
        for (int s = 1; s <= 2; s++) begin
            tick();
            set_dones(5'b00001 << (s - 1));
            tick();
            set_dones(5'b00000);
        end
        for (int k = 0; k < TMO; k++) begin
            n_cmp++;
            if (state !== 3'd3 || exec_en !== (k == 0)) begin
                n_bad++;
                $display("FAIL exec_wait: k=%0d state=%0d exec_en=%b want 3", k, state, exec_en);
            end
            set_dones(5'b11011 & 5'($urandom));
            tick();
        end
        set_dones(5'b00000);
        n_cmp++;
        if (state !== 3'd7 || error !== 1'b1 || busy !== 1'b0 || en_vec !== 5'b0) begin
            n_bad++;
            $display("FAIL timeout_error: state=%0d err=%b busy=%b en=%b want 7 1 0 0",
                     state, error, busy, en_vec);
        end
        for (int k = 0; k < 6; k++) begin
            set_dones(5'($urandom) | 5'b00100);
            start = 1'b1;
            tick();
            n_cmp++;
            if (state !== 3'd7 || error !== 1'b1 || en_vec !== 5'b0) begin
                n_bad++;
                $display("FAIL error_sticky: state=%0d err=%b en=%b want 7 1 0", state, error, en_vec);
            end
        end
        set_dones(5'b00000);
        start = 1'b0;
        do_reset();
        check_reset_values("reset_clears_error");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_load_stall();
        test_store_branch();
        test_ignored_dones();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
